// File: rtl/treemux_rr_arb_if.sv
// Per-lane valid/ready ingress and registered one-hot egress between the
// packet arbiter and the TreeMux stage.
interface treemux_rr_arb_if #(
  parameter int WIDTH = 72,
  parameter int N     = 4
);
  localparam int SW = $clog2(N);

  logic [WIDTH-1:0] in_data  [N-1:0];
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_last;
  logic [N-1:0]     in_ready;
  logic             out_ready;
  logic [WIDTH-1:0] out_data [N-1:0];
  logic [N-1:0]     out_valid;
  logic             out_last;
  logic [SW-1:0]    out_src;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_src
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_src
  );
endinterface

// File: rtl/treemux_rr_arb.sv
// Packet-locking round-robin arbiter feeding the TreeMux pipelined mux with
// registered per-lane data and a one-hot valid pulse per beat.
module treemux_rr_lane #(
  parameter int WIDTH = 72
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge CLK) begin
    if (RST)     q <= '0;
    else if (en) q <= d;
  end
endmodule

module treemux_rr_arb #(
  parameter int WIDTH = 72,
  parameter int N     = 4
) (
  input  logic              CLK,
  input  logic              RST,
  treemux_rr_arb_if.slave   bus
);
  localparam int SW = $clog2(N);

  logic          lock;
  logic [SW-1:0] owner, ptr, gidx;
  logic [N-1:0]  grant;
  logic [SW:0]   cand;
  logic          found, xfer;

  // Locked: owner only, even if it bubbles. Unlocked: first valid from ptr.
  always_comb begin
    grant = '0;
    gidx  = ptr;
    found = 1'b0;
    cand  = '0;
    if (lock) begin
      grant[owner] = 1'b1;
      gidx         = owner;
    end else begin
      for (int j = 0; j < N; j++) begin
        cand = {1'b0, ptr} + (SW+1)'(j);
        if (cand >= (SW+1)'(N)) cand = cand - (SW+1)'(N);
        if (!found && bus.in_valid[cand[SW-1:0]]) begin
          found                 = 1'b1;
          grant[cand[SW-1:0]]   = 1'b1;
          gidx                  = cand[SW-1:0];
        end
      end
    end
  end

  assign bus.in_ready = {N{!RST && bus.out_ready}} & grant;
  assign xfer         = |(bus.in_valid & bus.in_ready);

  always_ff @(posedge CLK) begin
    if (RST) begin
      lock          <= 1'b0;
      owner         <= '0;
      ptr           <= '0;
      bus.out_valid <= '0;
      bus.out_last  <= 1'b0;
      bus.out_src   <= '0;
    end else begin
      bus.out_valid <= '0;
      if (xfer) begin
        bus.out_valid <= grant;
        bus.out_last  <= bus.in_last[gidx];
        bus.out_src   <= gidx;
        if (bus.in_last[gidx]) begin
          lock <= 1'b0;
          ptr  <= (gidx == SW'(N-1)) ? '0 : gidx + 1'b1;
        end else begin
          lock  <= 1'b1;
          owner <= gidx;
        end
      end
    end
  end

  // Non-granted lanes keep stale data; the mux only looks at the valid lane.
  logic [WIDTH-1:0] dq [N-1:0];
  for (genvar i = 0; i < N; i++) begin : g_lane
    treemux_rr_lane #(.WIDTH(WIDTH)) u_lane (
      .CLK (CLK),
      .RST (RST),
      .en  (xfer && grant[i]),
      .d   (bus.in_data[i]),
      .q   (dq[i])
    );
    assign bus.out_data[i] = dq[i];
  end

  a_onehot: assert property (@(posedge CLK)
    $onehot0(bus.out_valid) && $onehot0(bus.in_ready));
endmodule
